// File: rtl/mem_arbiter_s.sv
// rtl/mem_arbiter_s.sv - shared memory port sequencer for fetch and data requesters
// Define ARB_RR_EN for round-robin arbitration; otherwise data beats fetch.
module mem_arbiter_s #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   output logic              err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              owner_d_q, owner_d_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;
   logic              err_q, err_d;
   logic              grant_d;

`ifdef ARB_RR_EN
   logic              last_owner_q, last_owner_d;

   // Under contention, hand the port to whoever did not have it last (1 = data).
   assign grant_d = d_req & (~if_req | ~last_owner_q);
`else
   assign grant_d = d_req;
`endif

   always_comb begin
      state_d     = state_q;
      wd_d        = wd_q;
      owner_d_d   = owner_d_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = if_done_q;
      d_done_d    = d_done_q;
      err_d       = err_q;
`ifdef ARB_RR_EN
      last_owner_d = last_owner_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (if_req | d_req) begin
               owner_d_d   = grant_d;
               mem_en_d    = 1'b1;
               mem_we_d    = grant_d & d_we;
               mem_addr_d  = grant_d ? d_addr : if_addr;
               mem_wdata_d = grant_d ? d_wdata : '0;
               wd_d        = '0;
               state_d     = S_ACCESS;
`ifdef ARB_RR_EN
               last_owner_d = grant_d;
`endif
            end
         end
         S_ACCESS: begin
            // A ready on the watchdog's final cycle still completes normally.
            if (mem_ready) begin
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               err_d    = 1'b0;
               state_d  = S_RESP;
               if (owner_d_q) begin
                  d_rdata_d = mem_we_q ? '0 : mem_rdata;
                  d_done_d  = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_done_d  = 1'b1;
               end
            end else if (wd_q == WD_LAST) begin
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               err_d    = 1'b1;
               state_d  = S_RESP;
               if (owner_d_q) begin
                  d_rdata_d = '0;
                  d_done_d  = 1'b1;
               end else begin
                  if_rdata_d = '0;
                  if_done_d  = 1'b1;
               end
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_RESP: begin
            if_done_d = 1'b0;
            d_done_d  = 1'b0;
            err_d     = 1'b0;
            wd_d      = '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wd_q        <= '0;
         owner_d_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wd_q        <= wd_d;
         owner_d_q   <= owner_d_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         err_q       <= err_d;
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner_q <= 1'b0;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end
`endif

   assign if_rdata  = if_rdata_q;
   assign if_done   = if_done_q;
   assign d_rdata   = d_rdata_q;
   assign d_done    = d_done_q;
   assign err       = err_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_stall  = if_req & ~if_done_q;
   assign d_stall   = d_req & ~d_done_q;

endmodule
